// File: rtl/data_memory_sized.sv
// Word-organised data memory with byte/half/word loads and stores, sign/zero extension and error reporting.
// Latency: rsp_valid_o pulses LATENCY+1 cycles after the accept cycle; one request per LATENCY+2 cycles.
// Backpressure: req_ready_o is high only in IDLE; req_valid_i while not ready is ignored, not queued.
module data_memory_sized #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        wr_en_i,
  input  logic [1:0]  size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rd_data_o,
  output logic        err_o
);

  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit         NO_WAIT   = (LATENCY == 0);
  localparam logic [3:0] LAST_WAIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        err_q;
  logic [31:0] rd_data_q;

  // Request fields captured at accept
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Memory contents survive reset
  logic [31:0] mem_q [DEPTH];

  // Request as seen on the commit edge: live inputs when there is no wait state, latched fields otherwise
  logic        c_wr;
  logic        c_uns;
  logic [1:0]  c_size;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        commit;
  logic        c_err;
  logic [1:0]  c_lane;
  logic [IW-1:0] c_idx;
  logic [31:0] c_word;
  logic [31:0] c_shift;
  logic [31:0] c_load;
  logic [3:0]  c_be;
  logic [31:0] c_wsh;

  // Decode the committing request: error flags, load extraction and store byte enables
  always_comb begin
    c_wr    = NO_WAIT ? wr_en_i       : wr_q;
    c_uns   = NO_WAIT ? ld_unsigned_i : uns_q;
    c_size  = NO_WAIT ? size_i        : size_q;
    c_addr  = NO_WAIT ? addr_i        : addr_q;
    c_wdata = NO_WAIT ? wr_data_i     : wdata_q;
    commit  = NO_WAIT ? (state_q == S_IDLE && req_valid_i)
                      : (state_q == S_WAIT && cnt_q == LAST_WAIT);

    c_lane = c_addr[1:0];
    c_idx  = c_addr[IW+1:2];
    c_err  = ({2'b00, c_addr[31:2]} >= 32'(DEPTH))
           || (c_size == 2'b11)
           || (c_size == 2'b01 && c_addr[0])
           || (c_size == 2'b10 && c_lane != 2'b00);

    c_word  = mem_q[c_idx];
    c_shift = c_word >> {c_lane, 3'b000};
    c_load  = 32'd0;
    c_be    = 4'b0000;
    case (c_size)
      2'b00: begin
        c_load = c_uns ? {24'd0, c_shift[7:0]} : {{24{c_shift[7]}}, c_shift[7:0]};
        c_be   = 4'b0001 << c_lane;
      end
      2'b01: begin
        c_load = c_uns ? {16'd0, c_shift[15:0]} : {{16{c_shift[15]}}, c_shift[15:0]};
        c_be   = 4'b0011 << c_lane;
      end
      2'b10: begin
        c_load = c_word;
        c_be   = 4'b1111;
      end
      default: begin
        c_load = 32'd0;
        c_be   = 4'b0000;
      end
    endcase
    if (c_err || c_wr) begin
      c_load = 32'd0;
    end
    c_wsh = c_wdata << {c_lane, 3'b000};
  end

  // Byte-lane store on the edge entering RESP; suppressed by errors and by reset
  always_ff @(posedge clk_i) begin
    if (!reset_i && commit && c_wr && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) begin
          mem_q[c_idx][8*b +: 8] <= c_wsh[8*b +: 8];
        end
      end
    end
  end

  // Request FSM with registered handshake and response outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rd_data_q   <= 32'd0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            wr_q        <= wr_en_i;
            uns_q       <= ld_unsigned_i;
            size_q      <= size_i;
            addr_q      <= addr_i;
            wdata_q     <= wr_data_i;
            req_ready_q <= 1'b0;
            cnt_q       <= 4'd0;
            if (NO_WAIT) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rd_data_q   <= c_load;
              err_q       <= c_err;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == LAST_WAIT) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rd_data_q   <= c_load;
            err_q       <= c_err;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          cnt_q       <= 4'd0;
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          cnt_q       <= 4'd0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rd_data_o   = rd_data_q;
  assign err_o       = err_q;

endmodule
